// File: rtl/debug_unit_ctrl.sv
// Host command controller for the MIPS debug path: run/halt/step the pipeline via a
// clock enable and stream NWORDS debug words to the UART transmitter, MSB byte first.
module debug_unit_ctrl #(
  parameter int unsigned NWORDS   = 40,
  parameter int unsigned IDX_W    = 6,
  parameter logic [7:0]  CMD_RUN  = 8'h72,
  parameter logic [7:0]  CMD_HALT = 8'h68,
  parameter logic [7:0]  CMD_STEP = 8'h73,
  parameter logic [7:0]  CMD_DUMP = 8'h64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_done_tick,
  input  logic [7:0]       rx_data,
  input  logic             tx_ready,
  input  logic             tx_done_tick,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic [IDX_W-1:0] word_idx,
  input  logic [31:0]      word_data,
  output logic             pipe_en,
  output logic             halted,
  output logic             busy
);

  typedef enum logic [2:0] {S_HALT, S_RUN, S_STEP, S_LOAD, S_SEND, S_WAIT} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] shreg;
  logic [1:0]  byte_cnt;

  always_comb begin
    state_next = state;
    case (state)
      S_HALT: begin
        if (rx_done_tick) begin
          if (rx_data == CMD_RUN)       state_next = S_RUN;
          else if (rx_data == CMD_STEP) state_next = S_STEP;
          else if (rx_data == CMD_DUMP) state_next = S_LOAD;
        end
      end
      S_RUN: begin
        if (rx_done_tick) begin
          if (rx_data == CMD_HALT)      state_next = S_HALT;
          else if (rx_data == CMD_DUMP) state_next = S_LOAD;
        end
      end
      S_STEP: state_next = S_LOAD;
      // An idle transmitter lets the first byte of a word go out straight from LOAD.
      S_LOAD: state_next = tx_ready ? S_WAIT : S_SEND;
      S_SEND: state_next = tx_ready ? S_WAIT : S_SEND;
      S_WAIT: begin
        if (tx_done_tick) begin
          if (byte_cnt != 2'd3)         state_next = S_SEND;
          else if (word_idx == LAST_IDX) state_next = S_HALT;
          else                          state_next = S_LOAD;
        end
      end
      default: state_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_HALT;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      word_idx <= '0;
      pipe_en  <= 1'b0;
      halted   <= 1'b1;
      busy     <= 1'b0;
      shreg    <= 32'h0;
      byte_cnt <= 2'd0;
    end else begin
      state    <= state_next;
      tx_start <= 1'b0;
      pipe_en  <= (state_next == S_RUN) || (state_next == S_STEP);
      halted   <= !((state_next == S_RUN) || (state_next == S_STEP));
      busy     <= (state_next == S_LOAD) || (state_next == S_SEND) || (state_next == S_WAIT);
      case (state)
        S_LOAD: begin
          shreg    <= word_data;
          byte_cnt <= 2'd0;
          if (tx_ready) begin
            tx_start <= 1'b1;
            tx_data  <= word_data[31:24];
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            tx_start <= 1'b1;
            tx_data  <= shreg[31:24];
          end
        end
        S_WAIT: begin
          if (tx_done_tick) begin
            shreg    <= {shreg[23:0], 8'h00};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              word_idx <= (word_idx == LAST_IDX) ? '0 : word_idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Randomized bench for debug_unit_ctrl: an abstract run/step/dump model feeds a byte
// scoreboard and per-cycle status expectations; a UART model answers tx_start.
module tb_debug_unit_ctrl;
  localparam int NWORDS = 5;
  localparam int IDX_W  = 3;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_DUMP = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx_done_tick = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             tx_ready = 1'b1;
  logic             tx_done_tick = 1'b0;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      word_data;
  logic             pipe_en;
  logic             halted;
  logic             busy;

  logic [31:0]  mem [0:7];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           mode = M_IDLE;
  int           done_cnt = 0;
  byte unsigned exp_q [$];
  logic         block = 1'b0;
  int           pe_cnt = 0;
  bit           lat_armed = 1'b0;
  int           lat_cyc = 0;

  always #5 clk = ~clk;

  debug_unit_ctrl #(.NWORDS(NWORDS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_done_tick(tx_done_tick), .tx_start(tx_start),
    .tx_data(tx_data), .word_idx(word_idx), .word_data(word_data),
    .pipe_en(pipe_en), .halted(halted), .busy(busy)
  );

  assign word_data = mem[word_idx];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push_dump();
    for (int i = 0; i < NWORDS; i++)
      for (int b = 3; b >= 0; b--)
        exp_q.push_back(mem[i][8*b +: 8]);
  endtask

  // Reference model: a dump is exactly 4*NWORDS completed bytes, commands only count when idle or running.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= M_IDLE;
      done_cnt <= 0;
      exp_q.delete();
    end else begin
      case (mode)
        M_IDLE: if (rx_done_tick) begin
          if (rx_data == 8'h72) mode <= M_RUN;
          else if (rx_data == 8'h73) mode <= M_STEP;
          else if (rx_data == 8'h64) begin mode <= M_DUMP; done_cnt <= 0; push_dump(); end
        end
        M_RUN: if (rx_done_tick) begin
          if (rx_data == 8'h68) mode <= M_IDLE;
          else if (rx_data == 8'h64) begin mode <= M_DUMP; done_cnt <= 0; push_dump(); end
        end
        M_STEP: begin mode <= M_DUMP; done_cnt <= 0; push_dump(); end
        default: if (tx_done_tick) begin
          if (done_cnt == 4*NWORDS - 1) begin mode <= M_IDLE; done_cnt <= 0; end
          else done_cnt <= done_cnt + 1;
        end
      endcase
    end
  end

  initial begin : monitor
    logic        ready_prev;
    byte unsigned exp;
    ready_prev = 1'b1;
    forever begin
      @(negedge clk);
      chk("pipe_en", pipe_en, (mode == M_RUN) || (mode == M_STEP));
      chk("halted", halted, !((mode == M_RUN) || (mode == M_STEP)));
      chk("busy", busy, mode == M_DUMP);
      chk("word_idx_range", word_idx <= IDX_W'(NWORDS - 1), 1);
      if (mode != M_DUMP) chk("word_idx_idle", word_idx, 0);
      if (pipe_en) pe_cnt++;
      if (tx_start) begin
        chk("tx_start_ready", ready_prev, 1);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected got %02h want no tx_start (cycle %0d)", tx_data, cyc);
        end else begin
          exp = exp_q.pop_front();
          $display("tx byte %02h expected %02h cycle %0d", tx_data, exp, cyc);
          chk("tx_byte", tx_data, exp);
        end
        if (lat_armed) begin
          chk("dump_latency", cyc - lat_cyc, 2);
          lat_armed = 1'b0;
        end
      end
      ready_prev = tx_ready;
    end
  end

  initial begin : uart
    logic       busy_u;
    int         cnt;
    logic [7:0] cap;
    logic       start_seen;
    logic [7:0] data_seen;
    busy_u = 1'b0; cnt = 0; cap = 8'h00;
    forever begin
      @(negedge clk);
      start_seen = tx_start;
      data_seen  = tx_data;
      @(posedge clk); #1;
      tx_done_tick = 1'b0;
      if (!rst_n) busy_u = 1'b0;
      else if (busy_u) begin
        if (cnt == 0) begin
          chk("tx_data_stable", data_seen, cap);
          tx_done_tick = 1'b1;
          busy_u = 1'b0;
        end else cnt--;
      end else if (start_seen) begin
        busy_u = 1'b1;
        cnt = $urandom_range(0, 3);
        cap = data_seen;
      end
      tx_ready = !busy_u && !block;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic cmd(input logic [7:0] b);
    rx_data = b; rx_done_tick = 1'b1; lat_cyc = cyc;
    tick(1);
    rx_done_tick = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (mode != M_IDLE && n < 3000) begin tick(1); n++; end
    if (mode != M_IDLE) begin
      checks++; errors++;
      $display("FAIL wait_idle got mode %0d want idle within 3000 cycles", mode);
    end
  endtask

  task automatic cmd_on_done(input logic [7:0] b);
    int n = 0;
    while (!tx_done_tick && n < 500) begin tick(1); n++; end
    if (!tx_done_tick) begin
      checks++; errors++;
      $display("FAIL wait_tx_done got none want tx_done_tick within 500 cycles");
    end else cmd(b);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_word_idx"}, word_idx, 0);
    chk({tag, "_pipe_en"}, pipe_en, 0);
    chk({tag, "_halted"}, halted, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    byte unsigned tbl [6];
    logic [7:0] b;
    int n;
    tbl = '{8'h72, 8'h68, 8'h73, 8'h64, 8'h41, 8'h00};
    randomize_mem();
    tick(3);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick(2);

    // Unknown byte while halted.
    cmd(8'h41);
    tick(3);

    // Step with known words: exactly one enable cycle, then the dump.
    mem[0] = 32'hDEADBEEF; mem[1] = 32'h00000001;
    pe_cnt = 0;
    cmd(8'h73);
    wait_idle();
    chk("step_pulse", pe_cnt, 1);
    chk("step_queue_empty", exp_q.size(), 0);
    tick(2);

    // Dump from halt with transmitter idle: first tx_start two cycles after the command.
    randomize_mem();
    lat_armed = 1'b1;
    cmd(8'h64);
    wait_idle();
    chk("latency_seen", lat_armed, 0);
    tick(2);

    // Run window with an unknown byte in the middle.
    pe_cnt = 0;
    cmd(8'h72);
    tick(4);
    cmd(8'h41);
    tick(5);
    cmd(8'h68);
    tick(3);
    chk("run_window", pe_cnt, 11);

    // Dump requested while running, transmitter stalled for 50 cycles.
    cmd(8'h72);
    tick(5);
    block = 1'b1;
    tick(1);
    randomize_mem();
    cmd(8'h64);
    tick(50);
    block = 1'b0;
    wait_idle();

    // Commands mid-dump, one coincident with tx_done_tick.
    randomize_mem();
    cmd(8'h64);
    cmd_on_done(8'h72);
    tick(7);
    cmd(8'h73);
    wait_idle();
    chk("mid_dump_halted", halted, 1);
    tick(2);

    // Asynchronous reset between edges in the middle of a dump.
    randomize_mem();
    cmd(8'h64);
    tick(30);
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick(3);
    rst_n = 1'b1;
    tick(40);
    cmd(8'h64);
    wait_idle();

    // Random command stream.
    for (int it = 0; it < 25; it++) begin
      b = tbl[$urandom_range(0, 5)];
      if (b == 8'h00) b = 8'($urandom);
      if (mode == M_IDLE || mode == M_RUN) randomize_mem();
      cmd(b);
      tick($urandom_range(0, 40));
    end
    n = 0;
    while ((mode == M_DUMP || mode == M_STEP) && n < 3000) begin tick(1); n++; end
    if (mode == M_RUN) cmd(8'h68);
    wait_idle();
    tick(5);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_halted", halted, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
